// File: rtl/sad_min_select_pkg.sv
// Shared constants and types for the SAD minimum selector.
// SUM_LATENCY must track the SAD adder-tree pipeline depth.
package sad_min_select_pkg;

  localparam int SUM_LATENCY = 5;
  localparam int SAD_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

endpackage

// File: rtl/sad_min_select_if.sv
// Control/result bundle between the search sequencer and the
// SAD minimum selector.
interface sad_min_select_if #(
  parameter int MVW = 6
);
  import sad_min_select_pkg::*;

  logic                  start;
  logic                  cand_valid;
  logic [SAD_W-1:0]      sad_in;
  logic                  busy;
  logic                  done;
  logic [SAD_W-1:0]      best_sad;
  logic signed [MVW-1:0] best_mvx;
  logic signed [MVW-1:0] best_mvy;

  modport master (
    output start, cand_valid, sad_in,
    input  busy, done, best_sad, best_mvx, best_mvy
  );

  modport slave (
    input  start, cand_valid, sad_in,
    output busy, done, best_sad, best_mvx, best_mvy
  );

endinterface

// File: rtl/sad_tag_pipe.sv
// Valid delay line that realigns candidate tags with the SAD tree.
// Synchronous clear drops every in-flight tag.
module sad_tag_pipe
  import sad_min_select_pkg::*;
#(
  parameter int DEPTH = SUM_LATENCY
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (clr) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(din);
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/sad_min_select.sv
// Tracks the minimum SAD over a raster-ordered full-search window.
// Define SAD_ZERO_MV_BIAS_EN to favour the (0,0) candidate by ZMV_BIAS.
module sad_min_select
  import sad_min_select_pkg::*;
#(
  parameter int RANGE = 16,
  parameter int MVW   = 6
`ifdef SAD_ZERO_MV_BIAS_EN
  , parameter int ZMV_BIAS = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  sad_min_select_if.slave bus
);

  localparam int N  = (2 * RANGE) ** 2;
  localparam int CW = $clog2(N) + 1;

  localparam logic signed [MVW-1:0] LO  = MVW'(-RANGE);
  localparam logic signed [MVW-1:0] HI  = MVW'(RANGE - 1);
  localparam logic signed [MVW-1:0] ONE = MVW'(1);

  state_t state_q, state_d;

  logic [CW-1:0]         issue_cnt;
  logic signed [MVW-1:0] x, y;
  logic signed [MVW-1:0] run_x, run_y;
  logic [SAD_W-1:0]      run_min;
  logic [SAD_W-1:0]      eff_sad;
  logic [SAD_W-1:0]      best_sad;
  logic signed [MVW-1:0] best_mvx, best_mvy;
  logic tag_in, tag_out;
  logic consume, better, last;

  assign tag_in = bus.cand_valid
               && (state_q == S_SEARCH)
               && (issue_cnt < CW'(N));

  sad_tag_pipe #(
    .DEPTH (SUM_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

`ifdef SAD_ZERO_MV_BIAS_EN
  always_comb begin
    eff_sad = bus.sad_in;
    if (x == '0 && y == '0) begin
      if (bus.sad_in > SAD_W'(ZMV_BIAS))
        eff_sad = bus.sad_in - SAD_W'(ZMV_BIAS);
      else
        eff_sad = '0;
    end
  end
`else
  assign eff_sad = bus.sad_in;
`endif

  assign consume = tag_out && (state_q == S_SEARCH);
  assign better  = eff_sad < run_min;
  assign last    = consume && (x == HI) && (y == HI);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SEARCH;
      S_SEARCH: if (last)      state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      x         <= '0;
      y         <= '0;
      run_min   <= '1;
      run_x     <= '0;
      run_y     <= '0;
      best_sad  <= '1;
      best_mvx  <= '0;
      best_mvy  <= '0;
    end else begin
      if (state_q == S_IDLE && bus.start) begin
        issue_cnt <= '0;
        x         <= LO;
        y         <= LO;
        run_min   <= '1;
        run_x     <= '0;
        run_y     <= '0;
      end
      if (tag_in) issue_cnt <= issue_cnt + CW'(1);
      if (consume) begin
        if (better) begin
          run_min <= eff_sad;
          run_x   <= x;
          run_y   <= y;
        end
        if (x == HI) begin
          x <= LO;
          y <= y + ONE;
        end else begin
          x <= x + ONE;
        end
      end
      // fold the final candidate in directly; run_* is a cycle behind
      if (last) begin
        best_sad <= better ? eff_sad : run_min;
        best_mvx <= better ? x : run_x;
        best_mvy <= better ? y : run_y;
      end
    end
  end

  assign bus.busy     = (state_q == S_SEARCH);
  assign bus.done     = (state_q == S_DONE);
  assign bus.best_sad = best_sad;
  assign bus.best_mvx = best_mvx;
  assign bus.best_mvy = best_mvy;

endmodule

// File: tb/tb_sad_min_select.sv
// Randomized bench for sad_min_select with RANGE=2 (16 candidates).
// Expected results come from a direct min-search over the SAD table.
module tb_sad_min_select;

  localparam int RANGE = 2;
  localparam int NC    = 16;
  localparam int LAT   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sad_min_select_if #(.MVW(6)) bus ();

  sad_min_select #(
    .RANGE (RANGE),
    .MVW   (6)
`ifdef SAD_ZERO_MV_BIAS_EN
    , .ZMV_BIAS (16)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sad_tab [NC];
  int sched [int];
  int prev_best = 65535;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sched.exists(cyc)) begin
      bus.sad_in = 16'(sched[cyc]);
      sched.delete(cyc);
    end else begin
      bus.sad_in = 16'($urandom);
    end
  endtask

  function automatic void model(output int bs, output int bx,
                                output int by);
    int v, cx, cy;
    bs = 65535; bx = 0; by = 0;
    for (int i = 0; i < NC; i++) begin
      cx = i % (2 * RANGE) - RANGE;
      cy = i / (2 * RANGE) - RANGE;
      v  = sad_tab[i];
`ifdef SAD_ZERO_MV_BIAS_EN
      if (cx == 0 && cy == 0) v = (v > 16) ? v - 16 : 0;
`endif
      if (v < bs) begin
        bs = v; bx = cx; by = cy;
      end
    end
  endfunction

  // mode 0: continuous, 1: alternate cycles, 2: random gaps
  task automatic search(input string nm, input int mode,
                        input int extra, input bit inject);
    int issued, extra_left, last_iss, done_cnt, done_cyc, t;
    int es, ex, ey;
    bit cv;
    issued = 0; extra_left = extra; done_cnt = 0;
    last_iss = -100; done_cyc = -1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (t = 0; t < 200; t++) begin
      if (issued < NC) begin
        case (mode)
          0:       cv = 1'b1;
          1:       cv = (t % 2 == 0);
          default: cv = ($urandom % 3 != 0);
        endcase
      end else begin
        cv = (extra_left > 0);
      end
      bus.cand_valid = cv;
      bus.start = inject && (t == 3);
      if (cv && issued < NC) begin
        sched[cyc + LAT] = sad_tab[issued];
        issued++;
        last_iss = cyc;
      end else if (cv) begin
        extra_left--;
      end
      step();
      chk({nm, "_busy"}, int'(bus.busy),
          int'(done_cnt == 0 && !bus.done));
      if (done_cnt == 0 && !bus.done)
        chk({nm, "_hold"}, int'(bus.best_sad), prev_best);
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      if (done_cnt > 0 && !bus.done) break;
    end
    bus.cand_valid = 1'b0;
    bus.start = 1'b0;
    model(es, ex, ey);
    chk({nm, "_donelat"}, done_cyc - last_iss, LAT + 1);
    chk({nm, "_donecnt"}, done_cnt, 1);
    chk({nm, "_sad"}, int'(bus.best_sad), es);
    chk({nm, "_mvx"}, int'($signed(bus.best_mvx)), ex);
    chk({nm, "_mvy"}, int'($signed(bus.best_mvy)), ey);
    prev_best = es;
    step();
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NC; i++) sad_tab[i] = v;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cand_valid = 1'b0;
    bus.sad_in = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_sad", int'(bus.best_sad), 65535);
    chk("rst_mvx", int'($signed(bus.best_mvx)), 0);
    chk("rst_mvy", int'($signed(bus.best_mvy)), 0);
    rst = 1'b0;
    step();

    fill(100); sad_tab[9] = 7;
    search("cont", 0, 0, 1'b0);

    fill(50);
    search("tie", 0, 0, 1'b0);

    fill(100); sad_tab[9] = 7;
    search("toggle", 1, 3, 1'b0);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.cand_valid = 1'b1;
      sched[cyc + LAT] = 1;
      step();
    end
    bus.cand_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_sad", int'(bus.best_sad), 65535);
    chk("abort_mvx", int'($signed(bus.best_mvx)), 0);
    rst = 1'b0;
    sched.delete();
    prev_best = 65535;
    step();
    fill(100); sad_tab[9] = 7; sad_tab[2] = 300;
    search("after_abort", 0, 0, 1'b0);

    fill(90); sad_tab[5] = 3;
    search("restart", 0, 0, 1'b1);

    fill(200); sad_tab[10] = 20; sad_tab[15] = 10;
    search("zmv", 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NC; i++)
        sad_tab[i] = (r % 2 == 0) ? int'($urandom_range(0, 65535))
                                  : int'($urandom_range(0, 40));
      search($sformatf("rnd%0d", r), 2, int'($urandom_range(0, 4)),
             1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
